// File: rtl/dual_fetch_queue.sv
// Dual-issue fetch: aligned pair requests into a DEPTH-entry instruction queue; data visible 2 cycles after request.
// Backpressure: requests stall unless queue plus in-flight pair leaves room for another pair; decode pops 0-2/cycle.
module dual_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         imem_req,
  output logic [31:0]                  pc_f_0,
  output logic [31:0]                  pc_f_1,
  input  logic [31:0]                  imem_rdata_0,
  input  logic [31:0]                  imem_rdata_1,
  output logic [31:0]                  instr_d_0,
  output logic [31:0]                  instr_d_1,
  output logic [31:0]                  pc_d_0,
  output logic [31:0]                  pc_d_1,
  output logic                         valid_d_0,
  output logic                         valid_d_1,
  input  logic [1:0]                   dec_take,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0]   fq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_1, wr_ptr_1;
  logic [31:0]   fetch_pc;
  logic          skip_lo;
  logic          inflight;
  logic          inflight_skip;
  logic [31:0]   inflight_pc;
  logic [1:0]    take, enq_n, deq_n;
  logic          enq_vld;
  logic [31:0]   need;
  logic          unused_bits;

  assign unused_bits = ^redirect_pc[1:0];
  assign rd_ptr_1    = rd_ptr + PW'(1);
  assign wr_ptr_1    = wr_ptr + PW'(1);

  assign take = (dec_take == 2'd3) ? 2'd2 : dec_take;

  always_comb begin
    deq_n = take;
    if (fq_count < CW'(take)) deq_n = fq_count[1:0];
  end

  // A redirect in the response cycle kills the returning pair.
  assign enq_vld = inflight & ~redirect_valid;
  assign enq_n   = !enq_vld ? 2'd0 : (inflight_skip ? 2'd1 : 2'd2);

  // Reserve room for the pair already in flight plus the one about to be requested.
  assign need     = 32'(fq_count) + (inflight ? 32'd4 : 32'd2);
  assign imem_req = reset & ~redirect_valid & (need <= 32'(DEPTH));
  assign pc_f_0   = fetch_pc;
  assign pc_f_1   = fetch_pc + 32'd4;

  assign valid_d_0 = (fq_count != '0);
  assign valid_d_1 = (fq_count >= CW'(2));
  assign instr_d_0 = valid_d_0 ? q_instr[rd_ptr]   : 32'd0;
  assign pc_d_0    = valid_d_0 ? q_pc[rd_ptr]      : 32'd0;
  assign instr_d_1 = valid_d_1 ? q_instr[rd_ptr_1] : 32'd0;
  assign pc_d_1    = valid_d_1 ? q_pc[rd_ptr_1]    : 32'd0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fq_count      <= '0;
      inflight      <= 1'b0;
      inflight_skip <= 1'b0;
      inflight_pc   <= 32'd0;
      fetch_pc      <= RESET_PC & ~32'h7;
      skip_lo       <= RESET_PC[2];
    end else if (redirect_valid) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fq_count      <= '0;
      inflight      <= 1'b0;
      fetch_pc      <= redirect_pc & ~32'h7;
      skip_lo       <= redirect_pc[2];
    end else begin
      rd_ptr   <= rd_ptr + PW'(deq_n);
      wr_ptr   <= wr_ptr + PW'(enq_n);
      fq_count <= fq_count + CW'(enq_n) - CW'(deq_n);
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc   <= fetch_pc;
        inflight_skip <= skip_lo;
        fetch_pc      <= fetch_pc + 32'd8;
        skip_lo       <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && enq_vld) begin
      if (inflight_skip) begin
        q_instr[wr_ptr] <= imem_rdata_1;
        q_pc[wr_ptr]    <= inflight_pc + 32'd4;
      end else begin
        q_instr[wr_ptr]   <= imem_rdata_0;
        q_pc[wr_ptr]      <= inflight_pc;
        q_instr[wr_ptr_1] <= imem_rdata_1;
        q_pc[wr_ptr_1]    <= inflight_pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_dual_fetch_queue.sv
// Directed bench for dual_fetch_queue: memory returns (address ^ KEY) one cycle after each request.
module tb_dual_fetch_queue;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] pc_f_0, pc_f_1;
  logic [31:0] imem_rdata_0, imem_rdata_1;
  logic [31:0] instr_d_0, instr_d_1, pc_d_0, pc_d_1;
  logic        valid_d_0, valid_d_1;
  logic [1:0]  dec_take;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [3:0]  fq_count;
  logic [31:0] resp_a = 32'd0;
  logic [31:0] resp_b = 32'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    resp_a <= pc_f_0;
    resp_b <= pc_f_1;
  end
  assign imem_rdata_0 = resp_a ^ KEY;
  assign imem_rdata_1 = resp_b ^ KEY;

  dual_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .pc_f_0(pc_f_0), .pc_f_1(pc_f_1),
    .imem_rdata_0(imem_rdata_0), .imem_rdata_1(imem_rdata_1),
    .instr_d_0(instr_d_0), .instr_d_1(instr_d_1),
    .pc_d_0(pc_d_0), .pc_d_1(pc_d_1),
    .valid_d_0(valid_d_0), .valid_d_1(valid_d_1),
    .dec_take(dec_take), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fq_count(fq_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_head(input string tag, input logic [3:0] cnt, input logic [31:0] pc0,
                            input logic v1, input logic [31:0] pc1);
    check({tag, "_cnt"}, 32'(fq_count), 32'(cnt));
    check({tag, "_v0"}, 32'(valid_d_0), 32'(cnt != 4'd0));
    check({tag, "_pc0"}, pc_d_0, pc0);
    check({tag, "_i0"}, instr_d_0, (cnt != 4'd0) ? (pc0 ^ KEY) : 32'd0);
    check({tag, "_v1"}, 32'(valid_d_1), 32'(v1));
    check({tag, "_pc1"}, pc_d_1, pc1);
    check({tag, "_i1"}, instr_d_1, v1 ? (pc1 ^ KEY) : 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    dec_take = 2'd0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    tick();
    tick();
    check_head("rst", 4'd0, 32'd0, 1'b0, 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);

    // cycle 0 after release
    reset = 1'b1;
    dec_take = 2'd2;
    #1;
    check("c0_req", 32'(imem_req), 32'd1);
    check("c0_pcf0", pc_f_0, 32'h0);
    check("c0_pcf1", pc_f_1, 32'h4);
    tick();
    check("c1_req", 32'(imem_req), 32'd1);
    check("c1_pcf0", pc_f_0, 32'h8);
    check("c1_v0", 32'(valid_d_0), 32'd0);
    tick();
    check_head("c2", 4'd2, 32'h0, 1'b1, 32'h4);
    check("c2_pcf0", pc_f_0, 32'h10);
    for (int k = 3; k <= 7; k++) begin
      tick();
      check_head("stream", 4'd2, 32'(8 * (k - 2)), 1'b1, 32'(8 * (k - 2) + 4));
      check("stream_req", 32'(imem_req), 32'd1);
    end

    // back-pressure: cycles 7..16 take nothing
    dec_take = 2'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_cnt", 32'(fq_count), (i == 0) ? 32'd4 : (i == 1) ? 32'd6 : 32'd8);
      check("bp_req", 32'(imem_req), (i == 0) ? 32'd1 : 32'd0);
      check("bp_pc0", pc_d_0, 32'h28);
    end
    dec_take = 2'd2;
    for (int j = 0; j < 12; j++) begin
      tick();
      check_head("rel", (j == 0) ? 4'd6 : 4'd4, 32'h30 + 32'(8 * j), 1'b1, 32'h34 + 32'(8 * j));
    end

    // odd redirect to 0x1C with a response in flight, then partial takes
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_001C;
    dec_take = 2'd0;
    #1;
    check("rdA_req", 32'(imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check_head("rdA", 4'd0, 32'd0, 1'b0, 32'd0);
    check("rdA_pcf0", pc_f_0, 32'h18);
    check("rdA_req1", 32'(imem_req), 32'd1);
    tick();
    check("rdB_cnt", 32'(fq_count), 32'd0);
    check("rdB_pcf0", pc_f_0, 32'h20);
    tick();
    check_head("rdC", 4'd1, 32'h1C, 1'b0, 32'd0);
    tick();
    check_head("rdD", 4'd3, 32'h1C, 1'b1, 32'h20);
    dec_take = 2'd1;
    tick();
    check_head("take1a", 4'd4, 32'h20, 1'b1, 32'h24);
    check("take1a_req", 32'(imem_req), 32'd1);
    tick();
    check_head("take1b", 4'd5, 32'h24, 1'b1, 32'h28);
    check("take1b_req", 32'(imem_req), 32'd0);

    // odd redirect to 0x104 killing the in-flight pair, then over-take
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0104;
    dec_take = 2'd2;
    tick();
    redirect_valid = 1'b0;
    #1;
    check_head("rr1", 4'd0, 32'd0, 1'b0, 32'd0);
    check("rr1_pcf0", pc_f_0, 32'h100);
    tick();
    check("rr2_cnt", 32'(fq_count), 32'd0);
    check("rr2_pcf0", pc_f_0, 32'h108);
    tick();
    check_head("rr3", 4'd1, 32'h104, 1'b0, 32'd0);
    tick();
    check_head("over", 4'd2, 32'h108, 1'b1, 32'h10C);
    dec_take = 2'd3;
    tick();
    check_head("take3", 4'd2, 32'h110, 1'b1, 32'h114);

    // wrap through the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("wr_pcf0", pc_f_0, 32'hFFFF_FFF8);
    check("wr_pcf1", pc_f_1, 32'hFFFF_FFFC);
    tick();
    check("wr_pcf0b", pc_f_0, 32'h0);
    tick();
    check_head("wr1", 4'd2, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFFC);
    tick();
    check_head("wr2", 4'd2, 32'h0, 1'b1, 32'h4);

    // reset mid-stream
    reset = 1'b0;
    #1;
    check("mr_req", 32'(imem_req), 32'd0);
    tick();
    check_head("mr", 4'd0, 32'd0, 1'b0, 32'd0);
    reset = 1'b1;
    #1;
    check("mr_req1", 32'(imem_req), 32'd1);
    check("mr_pcf0", pc_f_0, 32'h0);
    tick();
    check("mr2_pcf0", pc_f_0, 32'h8);
    check("mr2_cnt", 32'(fq_count), 32'd0);
    tick();
    check_head("mr3", 4'd2, 32'h0, 1'b1, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
